// File: rtl/escalonador_recurso.sv
// Two-requester resource scheduler with profile priority, tie alternation,
// anti-starvation forcing and bounded grant slots.
module escalonador_recurso #(
   parameter int SLOT_CYCLES = 8,
   parameter int MAX_CONSEC  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req01,
   input  logic        req02,
   input  logic [2:0]  perfil01,
   input  logic [2:0]  perfil02,
   input  logic [2:0]  func01,
   input  logic [2:0]  func02,
   output logic        gnt01,
   output logic        gnt02,
   output logic [11:0] out,
   output logic        LED_r,
   output logic        LED_g,
   output logic        LED_b,
   output logic [1:0]  estado
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      GRANT01     = 2'd1,
      GRANT02     = 2'd2,
      GRANT_AMBOS = 2'd3
   } estado_t;

   localparam logic [7:0] SLOT_LAST = 8'(SLOT_CYCLES - 1);
   localparam logic [7:0] CONSEC_MAX = 8'(MAX_CONSEC);

   estado_t     estado_q, estado_d;
   logic        gnt01_q, gnt01_d;
   logic        gnt02_q, gnt02_d;
   logic [11:0] out_q, out_d;
   logic        led_r_q, led_r_d;
   logic        led_g_q, led_g_d;
   logic        led_b_q, led_b_d;
   logic [7:0]  slot_q, slot_d;
   logic [7:0]  consec_q, consec_d;
   logic        last02_q, last02_d;

   logic [1:0]  nivel01;
   logic [1:0]  nivel02;
   logic        conflito;
   logic        win01;
   logic        keep01;
   logic        keep02;
   logic        expira;

   function automatic logic [1:0] nivel(input logic [2:0] p);
      logic [1:0] n;
      n = 2'd0;
      if (p[2])
         n = 2'd3;
      else if (p[1])
         n = 2'd2;
      else if (p[0])
         n = 2'd1;
      return n;
   endfunction

   assign nivel01  = nivel(perfil01);
   assign nivel02  = nivel(perfil02);
   assign conflito = req01 & req02 & (|(func01 & func02));

   // last02_q=1 means IE02 won the last conflict, so IE01 is "the other side"
   always_comb begin
      win01 = last02_q;
      if (consec_q == CONSEC_MAX)
         win01 = last02_q;
      else if (nivel01 > nivel02)
         win01 = 1'b1;
      else if (nivel01 < nivel02)
         win01 = 1'b0;
   end

   assign keep01 = gnt01_q & req01;
   assign keep02 = gnt02_q & req02;
   assign expira = (slot_q == SLOT_LAST);

   always_comb begin
      estado_d = estado_q;
      gnt01_d  = gnt01_q;
      gnt02_d  = gnt02_q;
      out_d    = out_q;
      slot_d   = slot_q;
      consec_d = consec_q;
      last02_d = last02_q;
      case (estado_q)
         IDLE: begin
            gnt01_d = 1'b0;
            gnt02_d = 1'b0;
            out_d   = 12'd0;
            slot_d  = 8'd0;
            if (conflito) begin
               last02_d = ~win01;
               if (win01 == ~last02_q)
                  consec_d = consec_q + 8'd1;
               else
                  consec_d = 8'd1;
               if (win01) begin
                  estado_d   = GRANT01;
                  gnt01_d    = 1'b1;
                  out_d[5:0] = {func01, perfil01};
               end else begin
                  estado_d    = GRANT02;
                  gnt02_d     = 1'b1;
                  out_d[11:6] = {func02, perfil02};
               end
            end else if (req01 && req02) begin
               estado_d = GRANT_AMBOS;
               gnt01_d  = 1'b1;
               gnt02_d  = 1'b1;
               out_d    = {func02, perfil02, func01, perfil01};
            end else if (req01) begin
               estado_d   = GRANT01;
               gnt01_d    = 1'b1;
               out_d[5:0] = {func01, perfil01};
            end else if (req02) begin
               estado_d    = GRANT02;
               gnt02_d     = 1'b1;
               out_d[11:6] = {func02, perfil02};
            end
         end
         GRANT01, GRANT02, GRANT_AMBOS: begin
            // a released side stays released until the slot ends
            if (expira || !(keep01 || keep02)) begin
               estado_d = IDLE;
               gnt01_d  = 1'b0;
               gnt02_d  = 1'b0;
               out_d    = 12'd0;
               slot_d   = 8'd0;
            end else begin
               gnt01_d = keep01;
               gnt02_d = keep02;
               out_d   = out_q & {{6{keep02}}, {6{keep01}}};
               slot_d  = slot_q + 8'd1;
            end
         end
         default: estado_d = IDLE;
      endcase
      led_b_d = gnt01_d & ~gnt02_d;
      led_r_d = gnt02_d & ~gnt01_d;
      led_g_d = gnt01_d & gnt02_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q <= IDLE;
         gnt01_q  <= 1'b0;
         gnt02_q  <= 1'b0;
         out_q    <= 12'd0;
         led_r_q  <= 1'b0;
         led_g_q  <= 1'b0;
         led_b_q  <= 1'b0;
         slot_q   <= 8'd0;
         consec_q <= 8'd0;
         last02_q <= 1'b1;
      end else begin
         estado_q <= estado_d;
         gnt01_q  <= gnt01_d;
         gnt02_q  <= gnt02_d;
         out_q    <= out_d;
         led_r_q  <= led_r_d;
         led_g_q  <= led_g_d;
         led_b_q  <= led_b_d;
         slot_q   <= slot_d;
         consec_q <= consec_d;
         last02_q <= last02_d;
      end
   end

   assign estado = estado_q;
   assign gnt01  = gnt01_q;
   assign gnt02  = gnt02_q;
   assign out    = out_q;
   assign LED_r  = led_r_q;
   assign LED_g  = led_g_q;
   assign LED_b  = led_b_q;

endmodule

// File: tb/tb_escalonador_recurso.sv
// Scoreboard bench for escalonador_recurso: directed scenarios plus random
// traffic checked against a slot/fairness reference model.
module tb_escalonador_recurso;

   localparam int SLOT = 8;
   localparam int MAXC = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req01 = 1'b0;
   logic        req02 = 1'b0;
   logic [2:0]  perfil01 = 3'd0;
   logic [2:0]  perfil02 = 3'd0;
   logic [2:0]  func01 = 3'd0;
   logic [2:0]  func02 = 3'd0;
   logic        gnt01;
   logic        gnt02;
   logic [11:0] out;
   logic        LED_r;
   logic        LED_g;
   logic        LED_b;
   logic [1:0]  estado;

   escalonador_recurso #(.SLOT_CYCLES(SLOT), .MAX_CONSEC(MAXC)) dut (
      .clk(clk), .rst(rst),
      .req01(req01), .req02(req02),
      .perfil01(perfil01), .perfil02(perfil02),
      .func01(func01), .func02(func02),
      .gnt01(gnt01), .gnt02(gnt02), .out(out),
      .LED_r(LED_r), .LED_g(LED_g), .LED_b(LED_b),
      .estado(estado)
   );

   always #5 clk = ~clk;

   logic [18:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int ncyc = 0;

   // reference model: a slot is "busy" with a set of holders
   bit         m_busy = 0;
   bit         m_both = 0;
   bit         m_g1 = 0;
   bit         m_g2 = 0;
   int         m_elapsed = 0;
   logic [5:0] m_f1 = 0;
   logic [5:0] m_f2 = 0;
   int         m_last = 2;
   int         m_streak = 0;

   function automatic int lvl(input logic [2:0] p);
      if (p[2]) return 3;
      if (p[1]) return 2;
      if (p[0]) return 1;
      return 0;
   endfunction

   task automatic step(input logic r, input logic r1,
                       input logic [2:0] p1, input logic [2:0] f1,
                       input logic r2, input logic [2:0] p2,
                       input logic [2:0] f2);
      int w;
      logic [1:0]  e_est;
      logic [11:0] e_out;
      @(negedge clk);
      rst = r; req01 = r1; req02 = r2;
      perfil01 = p1; func01 = f1;
      perfil02 = p2; func02 = f2;
      if (r) begin
         m_busy = 0; m_both = 0; m_g1 = 0; m_g2 = 0;
         m_last = 2; m_streak = 0;
      end else if (!m_busy) begin
         if (r1 || r2) begin
            m_busy = 1;
            m_elapsed = 1;
            m_f1 = {f1, p1};
            m_f2 = {f2, p2};
            if (r1 && r2 && ((f1 & f2) != 0)) begin
               if (m_streak == MAXC)
                  w = (m_last == 1) ? 2 : 1;
               else if (lvl(p1) > lvl(p2))
                  w = 1;
               else if (lvl(p1) < lvl(p2))
                  w = 2;
               else
                  w = (m_last == 1) ? 2 : 1;
               m_streak = (w == m_last) ? m_streak + 1 : 1;
               m_last = w;
               m_g1 = (w == 1);
               m_g2 = (w == 2);
               m_both = 0;
            end else begin
               m_g1 = r1;
               m_g2 = r2;
               m_both = r1 && r2;
            end
         end
      end else begin
         if (m_elapsed == SLOT) begin
            m_busy = 0; m_g1 = 0; m_g2 = 0;
         end else begin
            m_g1 = m_g1 && r1;
            m_g2 = m_g2 && r2;
            if (!(m_g1 || m_g2))
               m_busy = 0;
            else
               m_elapsed++;
         end
      end
      if (!m_busy) m_both = 0;
      e_est = !m_busy ? 2'd0 : m_both ? 2'd3 : m_g1 ? 2'd1 : 2'd2;
      e_out = {m_g2 ? m_f2 : 6'd0, m_g1 ? m_f1 : 6'd0};
      exp_q.push_back({e_est, m_g1, m_g2, e_out,
                       m_g2 & ~m_g1, m_g1 & m_g2, m_g1 & ~m_g2});
   endtask

   // monitor: one registered output set per clock
   initial begin
      logic [18:0] e;
      logic [18:0] a;
      forever begin
         @(posedge clk);
         #1;
         ncyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {estado, gnt01, gnt02, out, LED_r, LED_g, LED_b};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs cyc%0d got est=%0d g=%b%b out=%h rgb=%b%b%b want est=%0d g=%b%b out=%h rgb=%b%b%b",
                        ncyc, a[18:17], a[16], a[15], a[14:3], a[2], a[1], a[0],
                        e[18:17], e[16], e[15], e[14:3], e[2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      logic        r1, r2, rr;
      logic [2:0]  p1, p2, f1, f2;
      int          wait_n;
      repeat (2) step(1, 0, 0, 0, 0, 0, 0);
      // single requester, repeated slots
      repeat (20) step(0, 1, 3'b100, 3'b011, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      // conflict decided by level
      repeat (10) step(0, 1, 3'b001, 3'b001, 1, 3'b010, 3'b001);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      // tie alternation
      step(1, 0, 0, 0, 0, 0, 0);
      repeat (40) step(0, 1, 3'b100, 3'b111, 1, 3'b100, 3'b111);
      // anti-starvation
      step(1, 0, 0, 0, 0, 0, 0);
      repeat (80) step(0, 1, 3'b100, 3'b001, 1, 3'b001, 3'b001);
      // shared grant with early release of IE02
      step(1, 0, 0, 0, 0, 0, 0);
      repeat (4) step(0, 1, 3'b001, 3'b001, 1, 3'b010, 3'b110);
      repeat (3) step(0, 1, 3'b001, 3'b001, 0, 3'b010, 3'b110);
      step(0, 1, 3'b001, 3'b001, 1, 3'b010, 3'b110);
      repeat (6) step(0, 1, 3'b001, 3'b001, 1, 3'b010, 3'b110);
      // reset mid-slot then fresh tie
      step(1, 0, 0, 0, 0, 0, 0);
      repeat (5) step(0, 1, 3'b100, 3'b111, 1, 3'b100, 3'b111);
      step(1, 1, 3'b100, 3'b111, 1, 3'b100, 3'b111);
      repeat (12) step(0, 1, 3'b100, 3'b111, 1, 3'b100, 3'b111);
      // random traffic
      r1 = 0; r2 = 0;
      p1 = 0; p2 = 0; f1 = 0; f2 = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) r1 = ~r1;
         if ($urandom_range(0, 7) == 0) r2 = ~r2;
         if ($urandom_range(0, 15) == 0) p1 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) p2 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) f1 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) f2 = 3'($urandom_range(0, 7));
         rr = ($urandom_range(0, 99) == 0);
         step(rr, r1, p1, f1, r2, p2, f2);
      end
      wait_n = 0;
      while (exp_q.size() > 0 && wait_n < 10) begin
         @(posedge clk);
         #2;
         wait_n++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
